dfd_clk_en_ctrl: RTL and testbench

Per-domain activity-based clock-enable controller that drives the `en`, `hyst` and `force_en` inputs of a bank of `generic_ccg` cells. Each domain has a small FSM. After a programmable number of idle cycles the FSM drops that domain's enable. A wake request re-enables the domain, and the requester is acknowledged only after a fixed settle delay, so producers never send into a stopped clock. A saturating event counter exposes gating activity to DFD status registers.

---
 rtl/dfd_clk_en_ctrl.sv | 127 ++++++++++++
 tb/tb_dfd_clk_en_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfd_clk_en_ctrl.sv
// Activity-based clock-enable controller for a bank of generic_ccg cells: one small FSM per domain
// gates the domain after a programmable idle time and acks wake requests only once the clock is back.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | clock enabled, domain busy or requested
//   ST_IDLE | clock enabled, counting down idle cycles before gating
//   ST_OFF  | clock gated
//   ST_WAKE | clock re-enabled, waiting for the ccg enable flop to settle

module dfd_clk_en_ctrl #(
   parameter int NUM_DOM  = 4,
   parameter int IDLE_CYC = 16,
   parameter int WAKE_CYC = 2,
   parameter int EVT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_DOM-1:0] active,
   input  logic [NUM_DOM-1:0] wake_req,
   input  logic               csr_force_on,
   input  logic               csr_cnt_clr,
   output logic [NUM_DOM-1:0] clk_en,
   output logic               hyst_out,
   output logic               force_en_out,
   output logic [NUM_DOM-1:0] wake_ack,
   output logic [NUM_DOM-1:0] gated_sts,
   output logic [EVT_W-1:0]   gate_evt_cnt
);

   localparam int IC_W  = $clog2(IDLE_CYC + 1);
   localparam int WC_W  = $clog2(WAKE_CYC + 1);
   localparam int PC_W  = $clog2(NUM_DOM + 1);
   localparam int SUM_W = ((EVT_W > PC_W) ? EVT_W : PC_W) + 1;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;
   localparam logic [1:0] ST_WAKE = 2'd3;

   logic [NUM_DOM-1:0] wk;
   logic [NUM_DOM-1:0] to_off;
   logic [PC_W-1:0]    evt_inc;
   logic [SUM_W-1:0]   evt_sum;
   logic               evt_sat;

   assign wk       = active | wake_req | {NUM_DOM{csr_force_on}};
   assign hyst_out = |wake_req;

   for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
      logic [1:0]      state_q;
      logic [IC_W-1:0] idle_cnt_q;
      logic [WC_W-1:0] wake_cnt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (!wk[i]) begin
                     state_q    <= ST_IDLE;
                     idle_cnt_q <= IC_W'(IDLE_CYC - 1);
                  end
               end
               ST_IDLE: begin
                  if (wk[i]) begin
                     state_q <= ST_RUN;
                  end else if (idle_cnt_q == '0) begin
                     state_q <= ST_OFF;
                  end else begin
                     idle_cnt_q <= idle_cnt_q - IC_W'(1);
                  end
               end
               ST_OFF: begin
                  if (wk[i]) begin
                     state_q    <= ST_WAKE;
                     wake_cnt_q <= WC_W'(WAKE_CYC - 1);
                  end
               end
               default: begin
                  // WAKE always runs to completion so the ccg flop is settled before RUN
                  if (wake_cnt_q == '0) begin
                     state_q <= ST_RUN;
                  end else begin
                     wake_cnt_q <= wake_cnt_q - WC_W'(1);
                  end
               end
            endcase
         end
      end

      assign to_off[i]    = (state_q == ST_IDLE) & ~wk[i] & (idle_cnt_q == '0);
      assign clk_en[i]    = (state_q != ST_OFF);
      assign gated_sts[i] = (state_q == ST_OFF);
      assign wake_ack[i]  = wake_req[i] & (state_q == ST_RUN) & ~rst;
   end

   always_comb begin
      evt_inc = '0;
      for (int i = 0; i < NUM_DOM; i++) begin
         evt_inc = evt_inc + PC_W'(to_off[i]);
      end
   end

   assign evt_sum = SUM_W'(gate_evt_cnt) + SUM_W'(evt_inc);
   assign evt_sat = (evt_sum > SUM_W'({EVT_W{1'b1}}));

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_evt_cnt <= '0;
         force_en_out <= 1'b1;
      end else begin
         force_en_out <= csr_force_on;
         if (csr_cnt_clr) begin
            gate_evt_cnt <= '0;
         end else if (evt_sat) begin
            gate_evt_cnt <= '1;
         end else begin
            gate_evt_cnt <= evt_sum[EVT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_dfd_clk_en_ctrl.sv
// Self-checking bench for dfd_clk_en_ctrl: expected values are queued when stimulus is applied
// and popped when the DUT outputs are sampled on the falling edge.

module tb_dfd_clk_en_ctrl;

   localparam int NUM_DOM  = 4;
   localparam int IDLE_CYC = 16;
   localparam int WAKE_CYC = 2;
   localparam int EVT_W    = 4;
   localparam int EVT_MAX  = (1 << EVT_W) - 1;
   localparam int GATE_LAT = IDLE_CYC + 1;
   localparam int WAKE_LAT = WAKE_CYC + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_DOM-1:0] active;
   logic [NUM_DOM-1:0] wake_req;
   logic               csr_force_on;
   logic               csr_cnt_clr;
   logic [NUM_DOM-1:0] clk_en;
   logic               hyst_out;
   logic               force_en_out;
   logic [NUM_DOM-1:0] wake_ack;
   logic [NUM_DOM-1:0] gated_sts;
   logic [EVT_W-1:0]   gate_evt_cnt;

   logic [31:0] exp_q[$];
   logic [31:0] e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_cnt = 0;

   always #5 clk = ~clk;

   dfd_clk_en_ctrl #(
      .NUM_DOM (NUM_DOM),
      .IDLE_CYC(IDLE_CYC),
      .WAKE_CYC(WAKE_CYC),
      .EVT_W   (EVT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .active      (active),
      .wake_req    (wake_req),
      .csr_force_on(csr_force_on),
      .csr_cnt_clr (csr_cnt_clr),
      .clk_en      (clk_en),
      .hyst_out    (hyst_out),
      .force_en_out(force_en_out),
      .wake_ack    (wake_ack),
      .gated_sts   (gated_sts),
      .gate_evt_cnt(gate_evt_cnt)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int sat_add(input int a, input int b);
      return (a + b > EVT_MAX) ? EVT_MAX : a + b;
   endfunction

   // Returns negedges until clk_en reaches want, or -1 if it never does within the budget.
   task automatic wait_clk_en(input logic [NUM_DOM-1:0] want, input int limit, output int lat);
      lat = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (clk_en === want) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic force_round();
      int lat;
      csr_force_on = 1'b1;
      cyc(1);
      csr_force_on = 1'b0;
      exp_cnt = sat_add(exp_cnt, NUM_DOM);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'(exp_cnt));
      wait_clk_en('0, 40, lat);
      e = exp_q.pop_front(); n_tests++;
      if (32'(lat > 0) !== e) begin
         n_fail++; $display("FAIL round_gate: gated=%0d required=%0d", lat > 0, e);
      end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin
         n_fail++; $display("FAIL round_cnt: got %0d required %0d", gate_evt_cnt, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; active = '0; wake_req = '1; csr_force_on = 1'b0; csr_cnt_clr = 1'b0;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      cyc(2);
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL reset_clk_en: got %h required %h", clk_en, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gated_sts) !== e) begin n_fail++; $display("FAIL reset_gated: got %h required %h", gated_sts, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(wake_ack) !== e) begin n_fail++; $display("FAIL reset_ack_mask: got %h required %h", wake_ack, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(force_en_out) !== e) begin n_fail++; $display("FAIL reset_force_en: got %h required %h", force_en_out, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL reset_cnt: got %0d required %0d", gate_evt_cnt, e); end
   endtask

   task automatic test_gate_all();
      int lat;
      rst = 1'b0; wake_req = '0; active = '0;
      exp_cnt = sat_add(exp_cnt, NUM_DOM);
      exp_q.push_back(32'(GATE_LAT));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hF);
      exp_q.push_back(32'(exp_cnt));
      wait_clk_en('0, 40, lat);
      e = exp_q.pop_front(); n_tests++;
      if (32'(lat) !== e) begin n_fail++; $display("FAIL gate_latency: got %0d required %0d", lat, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL gate_clk_en: got %h required %h", clk_en, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gated_sts) !== e) begin n_fail++; $display("FAIL gate_sts: got %h required %h", gated_sts, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL gate_cnt: got %0d required %0d", gate_evt_cnt, e); end
   endtask

   task automatic test_wake();
      int lat = -1;
      int hyst_bad = 0;
      logic en0_first = 1'b0;
      wake_req = 4'b0001;
      exp_q.push_back(32'h1);
      exp_q.push_back(32'(WAKE_LAT));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) en0_first = clk_en[0];
         if (hyst_out !== 1'b1) hyst_bad++;
         if (wake_ack[0] === 1'b1) begin
            lat = k;
            break;
         end
      end
      e = exp_q.pop_front(); n_tests++;
      if (32'(en0_first) !== e) begin n_fail++; $display("FAIL wake_clk_en: got %b required %0d", en0_first, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(lat) !== e) begin n_fail++; $display("FAIL wake_ack_latency: got %0d required %0d", lat, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(hyst_bad) !== e) begin n_fail++; $display("FAIL wake_hyst: low cycles %0d required %0d", hyst_bad, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(wake_ack) !== e) begin n_fail++; $display("FAIL wake_ack_bits: got %h required %h", wake_ack, e); end
      wake_req = '0;
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_tests++;
      if (32'(hyst_out) !== e) begin n_fail++; $display("FAIL hyst_release: got %b required %0d", hyst_out, e); end
   endtask

   task automatic test_idle_abort();
      active = '1;
      cyc(4);
      active = '0;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'(exp_cnt));
      exp_cnt = sat_add(exp_cnt, NUM_DOM - 1);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'(exp_cnt));
      exp_q.push_back(32'h2);
      exp_cnt = sat_add(exp_cnt, 1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'(exp_cnt));
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == 14) active[1] = 1'b1;
         if (k == 15) active[1] = 1'b0;
         if (k == 16) begin
            e = exp_q.pop_front(); n_tests++;
            if (32'(clk_en) !== e) begin n_fail++; $display("FAIL abort_pre_clk_en: got %h required %h", clk_en, e); end
            e = exp_q.pop_front(); n_tests++;
            if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL abort_pre_cnt: got %0d required %0d", gate_evt_cnt, e); end
         end
         if (k == 17) begin
            e = exp_q.pop_front(); n_tests++;
            if (32'(clk_en) !== e) begin n_fail++; $display("FAIL abort_others_off: got %h required %h", clk_en, e); end
            e = exp_q.pop_front(); n_tests++;
            if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL abort_cnt3: got %0d required %0d", gate_evt_cnt, e); end
         end
         if (k == 31) begin
            e = exp_q.pop_front(); n_tests++;
            if (32'(clk_en) !== e) begin n_fail++; $display("FAIL abort_dom1_still_on: got %h required %h", clk_en, e); end
         end
         if (k == 32) begin
            e = exp_q.pop_front(); n_tests++;
            if (32'(clk_en) !== e) begin n_fail++; $display("FAIL abort_dom1_off: got %h required %h", clk_en, e); end
            e = exp_q.pop_front(); n_tests++;
            if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL abort_cnt1: got %0d required %0d", gate_evt_cnt, e); end
         end
      end
   endtask

   task automatic test_force();
      int lat;
      int held_bad = 0;
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_tests++;
      if (32'(force_en_out) !== e) begin n_fail++; $display("FAIL force_idle: got %b required %0d", force_en_out, e); end
      csr_force_on = 1'b1;
      exp_q.push_back(32'h1);
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      cyc(1);
      e = exp_q.pop_front(); n_tests++;
      if (32'(force_en_out) !== e) begin n_fail++; $display("FAIL force_en_out: got %b required %0d", force_en_out, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL force_wake: got %h required %h", clk_en, e); end
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (clk_en !== 4'hF) held_bad++;
      end
      e = exp_q.pop_front(); n_tests++;
      if (32'(held_bad) !== e) begin n_fail++; $display("FAIL force_hold: gated cycles %0d required %0d", held_bad, e); end
      csr_force_on = 1'b0;
      exp_cnt = sat_add(exp_cnt, NUM_DOM);
      exp_q.push_back(32'(GATE_LAT));
      exp_q.push_back(32'(exp_cnt));
      wait_clk_en('0, 40, lat);
      e = exp_q.pop_front(); n_tests++;
      if (32'(lat) !== e) begin n_fail++; $display("FAIL force_release_latency: got %0d required %0d", lat, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL force_cnt: got %0d required %0d", gate_evt_cnt, e); end
   endtask

   task automatic test_saturate();
      csr_cnt_clr = 1'b1;
      cyc(1);
      csr_cnt_clr = 1'b0;
      exp_cnt = 0;
      exp_q.push_back(32'(exp_cnt));
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL clr_idle: got %0d required %0d", gate_evt_cnt, e); end
      for (int r = 0; r < 5; r++) force_round();
      csr_force_on = 1'b1;
      cyc(1);
      csr_force_on = 1'b0;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      cyc(18);
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL clr_collide_pre: got %h required %h", clk_en, e); end
      csr_cnt_clr = 1'b1;
      cyc(1);
      csr_cnt_clr = 1'b0;
      exp_cnt = 0;
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL clr_collide_off: got %h required %h", clk_en, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL clr_collide_cnt: got %0d required %0d", gate_evt_cnt, e); end
   endtask

   task automatic test_reset_mid();
      int lat;
      force_round();
      active = 4'b1110;
      cyc(1);
      active = '0;
      cyc(2);
      wake_req = 4'b0001;
      cyc(1);
      rst = 1'b1;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      cyc(1);
      e = exp_q.pop_front(); n_tests++;
      if (32'(clk_en) !== e) begin n_fail++; $display("FAIL rstmid_clk_en: got %h required %h", clk_en, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(wake_ack) !== e) begin n_fail++; $display("FAIL rstmid_ack: got %h required %h", wake_ack, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL rstmid_cnt: got %0d required %0d", gate_evt_cnt, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(force_en_out) !== e) begin n_fail++; $display("FAIL rstmid_force_en: got %b required %0d", force_en_out, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gated_sts) !== e) begin n_fail++; $display("FAIL rstmid_gated: got %h required %h", gated_sts, e); end
      rst = 1'b0; wake_req = '0; active = '0;
      exp_cnt = sat_add(0, NUM_DOM);
      exp_q.push_back(32'(GATE_LAT));
      exp_q.push_back(32'(exp_cnt));
      wait_clk_en('0, 40, lat);
      e = exp_q.pop_front(); n_tests++;
      if (32'(lat) !== e) begin n_fail++; $display("FAIL rstmid_restart_latency: got %0d required %0d", lat, e); end
      e = exp_q.pop_front(); n_tests++;
      if (32'(gate_evt_cnt) !== e) begin n_fail++; $display("FAIL rstmid_restart_cnt: got %0d required %0d", gate_evt_cnt, e); end
   endtask

   initial begin
      test_reset();
      test_gate_all();
      test_wake();
      test_idle_abort();
      test_force();
      test_saturate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
